softmax_max_sched: RTL and testbench
====================================

Name: softmax_max_sched

Overview:
- Sequencing controller in front of the 64-lane, 6-stage pipelined max tree in the softmax-approximation datapath.
- Accepts 64x16-bit input beats over a valid/ready handshake and drives the tree's enable, lane-valid, data and length-mode inputs.
- Tracks in-flight beats and folds tree results across multi-beat segments (sequence length > 64) into running per-group maxima.
- Emits one result per segment to the exp/normalise stage, back-pressuring the tree when the result is not drained.

Parameters:
- DW, 16, element width (signed two's complement)
- LANES, 64, elements per beat
- LAT, 6, tree latency in enabled cycles
- NGRP, 4, maximum result groups (16-mode)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_in_valid  in  1  input beat valid
- o_in_ready  out  1  input beat accepted when valid&ready
- i_in_flat  in  LANES*DW  beat data, element k at [k*DW +: DW]
- i_in_lane_valid  in  LANES  per-element valid
- i_in_mode  in  4  0=64-mode, 1=32-mode, 2=16-mode
- i_in_last  in  1  last beat of segment
- o_tree_en  out  1  tree enable
- o_tree_rst  out  1  tree synchronous reset
- o_tree_length_mode  out  4  to tree
- o_tree_valid  out  LANES  to tree lane valids
- o_tree_flat  out  LANES*DW  to tree data
- i_tree_max64  in  DW  tree 64-mode output
- i_tree_max32  in  2*DW  tree 32-mode outputs {1,0}
- i_tree_max16  in  4*DW  tree 16-mode outputs {3..0}
- o_res_valid  out  1  segment result valid
- i_res_ready  in  1  result accepted when valid&ready
- o_res_max  out  NGRP*DW  group maxima, group g at [g*DW +: DW]; unused groups 0
- o_res_cnt  out  3  valid groups: 1, 2 or 4
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (async): o_res_valid=0, o_res_max=0, o_res_cnt=0, o_err=0, occupancy cleared, accumulators empty. o_tree_rst=1 while i_rst is high and for 1 cycle after release. o_in_ready=0 while o_tree_rst=1.
- Tree drive is combinational pass-through: o_tree_flat=i_in_flat, o_tree_length_mode=i_in_mode. o_tree_valid=i_in_lane_valid when the beat is accepted, else 0.
- Stall: stall=1 when tail slot holds a last beat, o_res_valid=1 and i_res_ready=0. o_tree_en=!stall and !o_tree_rst. o_in_ready=o_tree_en; it depends combinationally on i_res_ready.
- Occupancy: LAT-deep shift register of {occ, mode, last}. It advances only when o_tree_en=1. Slot 0 loads occ=in_valid&in_ready.
- The tail slot (index LAT-1) is aligned with the tree outputs. The tree's own o_valid_max is not used.
- Retire: occurs when o_tree_en=1 and tail occ=1. Selected values per mode:
  - 64-mode: max64 -> group 0
  - 32-mode: max32[0], max32[1] -> groups 0-1
  - 16-mode: max16[0..3] -> groups 0-3
- Accumulate (signed compare, ties keep accumulator):
  - accumulator empty: acc=selected, seg_mode latched
  - otherwise: acc[g]=max(acc[g], sel[g])
- Last retire: result register <= acc merged with current beat, unused groups 0, o_res_cnt per seg_mode, o_res_valid=1, accumulator set empty. Legal in the same cycle as a drain (i_res_ready=1); the new result wins.
- Drain without load: o_res_valid goes to 0; o_res_max holds its value.
- Single-beat segment (last on first beat) produces a result directly.
- Errors (set o_err sticky, cleared only by reset):
  - mode value > 2: treated as 64-mode
  - mode differing from seg_mode mid-segment: beat folded using seg_mode
- Throughput: 1 beat/cycle with no stall. First result appears LAT enabled cycles after the last beat is accepted.

Optional Feature:
- Macro: MAX_SCHED_PERF_EN.
- Defined: adds outputs o_perf_beats (32), o_perf_stalls (32), o_perf_segs (32), free-running wrap-around counters cleared by reset.
  - o_perf_beats: +1 per accepted beat
  - o_perf_stalls: +1 per cycle with stall=1
  - o_perf_segs: +1 per result load
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release: o_tree_rst high for 1 cycle after i_rst falls and o_in_ready=0 during it. 64-mode single beat, elements k-32 (max 31), last=1 -> 6 enabled cycles later o_res_valid=1, o_res_max group0=31, o_res_cnt=1.
- 32-mode 3-beat segment: group maxima per beat (5,-7), (9,-9), (2,-1) -> result groups {9,-1}, cnt=2, exactly one o_res_valid pulse.
- 16-mode back-to-back single-beat segments with i_res_ready held 0 -> second result stalls: o_tree_en=0, o_in_ready=0. i_res_ready=1 for one cycle -> first drained, second loaded the same cycle, no beat lost.
- Negative values: all elements -32768 except one at -2 -> result -2 (signed compare).
- Mode 5 on a beat, and 32-mode beat inside a 64-mode segment -> o_err=1 and stays 1; results computed with 64-mode.
- Async i_rst mid-segment with 4 beats in flight -> o_res_valid=0 immediately, no result after release. Next segment is unaffected by the pre-reset partial accumulation.

Source files
------------

// File: rtl/softmax_max_sched.sv
// rtl/softmax_max_sched.sv - sequencer and segment max folder for the 64-lane pipelined max tree
// Optional perf counters: define MAX_SCHED_PERF_EN.
module softmax_max_sched #(
    parameter int DW    = 16,
    parameter int LANES = 64,
    parameter int LAT   = 6,
    parameter int NGRP  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [LANES*DW-1:0]   i_in_flat,
    input  logic [LANES-1:0]      i_in_lane_valid,
    input  logic [3:0]            i_in_mode,
    input  logic                  i_in_last,
    output logic                  o_tree_en,
    output logic                  o_tree_rst,
    output logic [3:0]            o_tree_length_mode,
    output logic [LANES-1:0]      o_tree_valid,
    output logic [LANES*DW-1:0]   o_tree_flat,
    input  logic [DW-1:0]         i_tree_max64,
    input  logic [2*DW-1:0]       i_tree_max32,
    input  logic [4*DW-1:0]       i_tree_max16,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [NGRP*DW-1:0]    o_res_max,
    output logic [2:0]            o_res_cnt,
`ifdef MAX_SCHED_PERF_EN
    output logic [31:0]           o_perf_beats,
    output logic [31:0]           o_perf_stalls,
    output logic [31:0]           o_perf_segs,
`endif
    output logic                  o_err
);

    localparam logic [1:0] MODE_64 = 2'd0;
    localparam logic [1:0] MODE_32 = 2'd1;
    localparam logic [1:0] MODE_16 = 2'd2;

    logic                       tree_rst_q, tree_rst_d;
    logic [LAT-1:0]             occ_q, occ_d;
    logic [LAT-1:0]             last_q, last_d;
    logic [LAT-1:0][1:0]        mode_q, mode_d;
    logic signed [DW-1:0]       acc_q [NGRP];
    logic signed [DW-1:0]       acc_d [NGRP];
    logic                       acc_empty_q, acc_empty_d;
    logic [1:0]                 seg_mode_q, seg_mode_d;
    logic                       res_valid_q, res_valid_d;
    logic [NGRP*DW-1:0]         res_max_q, res_max_d;
    logic [2:0]                 res_cnt_q, res_cnt_d;
    logic                       err_q, err_d;

    logic                       in_mode_bad;
    logic [1:0]                 in_mode_n;
    logic                       stall, tree_en, accept, retire, mode_clash;
    logic [1:0]                 eff_mode;
    int                         grp_n;
    logic signed [DW-1:0]       sel    [NGRP];
    logic signed [DW-1:0]       merged [NGRP];

    always_comb begin
        in_mode_bad = i_in_mode > 4'd2;
        in_mode_n   = in_mode_bad ? MODE_64 : i_in_mode[1:0];
        // A finished segment at the tail may not retire over an undrained result.
        stall       = occ_q[LAT-1] & last_q[LAT-1] & res_valid_q & ~i_res_ready;
        tree_en     = ~stall & ~tree_rst_q;
        accept      = i_in_valid & tree_en;
        retire      = tree_en & occ_q[LAT-1];
        eff_mode    = acc_empty_q ? mode_q[LAT-1] : seg_mode_q;
        mode_clash  = retire & ~acc_empty_q & (mode_q[LAT-1] != seg_mode_q);

        for (int g = 0; g < NGRP; g++) begin
            sel[g] = '0;
        end
        case (eff_mode)
            MODE_32: begin
                sel[0] = i_tree_max32[DW-1:0];
                sel[1] = i_tree_max32[2*DW-1:DW];
                grp_n  = 2;
            end
            MODE_16: begin
                for (int g = 0; g < NGRP; g++) begin
                    sel[g] = i_tree_max16[g*DW +: DW];
                end
                grp_n = 4;
            end
            default: begin
                sel[0] = i_tree_max64;
                grp_n  = 1;
            end
        endcase

        for (int g = 0; g < NGRP; g++) begin
            merged[g] = (acc_empty_q || (sel[g] > acc_q[g])) ? sel[g] : acc_q[g];
        end
    end

    always_comb begin
        tree_rst_d  = 1'b0;
        occ_d       = occ_q;
        last_d      = last_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        acc_empty_d = acc_empty_q;
        seg_mode_d  = seg_mode_q;
        res_valid_d = res_valid_q;
        res_max_d   = res_max_q;
        res_cnt_d   = res_cnt_q;
        err_d       = err_q | (accept & in_mode_bad) | mode_clash;

        if (tree_en) begin
            occ_d  = {occ_q[LAT-2:0], accept};
            last_d = {last_q[LAT-2:0], i_in_last};
            mode_d = {mode_q[LAT-2:0], in_mode_n};
        end

        if (res_valid_q & i_res_ready) begin
            res_valid_d = 1'b0;
        end

        // A load in the same cycle as a drain overrides the clear above.
        if (retire) begin
            if (last_q[LAT-1]) begin
                for (int g = 0; g < NGRP; g++) begin
                    res_max_d[g*DW +: DW] = (g < grp_n) ? merged[g] : '0;
                end
                res_cnt_d   = 3'(grp_n);
                res_valid_d = 1'b1;
                acc_empty_d = 1'b1;
            end else begin
                acc_d       = merged;
                acc_empty_d = 1'b0;
                seg_mode_d  = eff_mode;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tree_rst_q  <= 1'b1;
            occ_q       <= '0;
            last_q      <= '0;
            mode_q      <= '0;
            for (int g = 0; g < NGRP; g++) begin
                acc_q[g] <= '0;
            end
            acc_empty_q <= 1'b1;
            seg_mode_q  <= MODE_64;
            res_valid_q <= 1'b0;
            res_max_q   <= '0;
            res_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            tree_rst_q  <= tree_rst_d;
            occ_q       <= occ_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            acc_empty_q <= acc_empty_d;
            seg_mode_q  <= seg_mode_d;
            res_valid_q <= res_valid_d;
            res_max_q   <= res_max_d;
            res_cnt_q   <= res_cnt_d;
            err_q       <= err_d;
        end
    end

    assign o_tree_rst         = tree_rst_q;
    assign o_tree_en          = tree_en;
    assign o_in_ready         = tree_en;
    assign o_tree_flat        = i_in_flat;
    assign o_tree_length_mode = i_in_mode;
    assign o_tree_valid       = accept ? i_in_lane_valid : '0;
    assign o_res_valid        = res_valid_q;
    assign o_res_max          = res_max_q;
    assign o_res_cnt          = res_cnt_q;
    assign o_err              = err_q;

`ifdef MAX_SCHED_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_segs_q, perf_segs_d;

    always_comb begin
        perf_beats_d  = perf_beats_q + 32'(accept);
        perf_stalls_d = perf_stalls_q + 32'(stall);
        perf_segs_d   = perf_segs_q + 32'(retire & last_q[LAT-1]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_beats_q  <= '0;
            perf_stalls_q <= '0;
            perf_segs_q   <= '0;
        end else begin
            perf_beats_q  <= perf_beats_d;
            perf_stalls_q <= perf_stalls_d;
            perf_segs_q   <= perf_segs_d;
        end
    end

    assign o_perf_beats  = perf_beats_q;
    assign o_perf_stalls = perf_stalls_q;
    assign o_perf_segs   = perf_segs_q;
`endif

endmodule

// File: tb/tb_softmax_max_sched.sv
// tb/tb_softmax_max_sched.sv - scoreboard bench for softmax_max_sched with a behavioural max-tree
module tb_softmax_max_sched;

    localparam int DW    = 16;
    localparam int LANES = 64;
    localparam int LAT   = 6;
    localparam int NGRP  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid, in_ready, in_last;
    logic [LANES*DW-1:0]   in_flat;
    logic [LANES-1:0]      in_lv;
    logic [3:0]            in_mode;
    logic                  tree_en, tree_rst;
    logic [3:0]            tree_lm;
    logic [LANES-1:0]      tree_valid;
    logic [LANES*DW-1:0]   tree_flat;
    logic [DW-1:0]         max64;
    logic [2*DW-1:0]       max32;
    logic [4*DW-1:0]       max16;
    logic                  res_valid, res_ready;
    logic [NGRP*DW-1:0]    res_max;
    logic [2:0]            res_cnt;
    logic                  err;
`ifdef MAX_SCHED_PERF_EN
    logic [31:0]           perf_beats, perf_stalls, perf_segs;
`endif

    always #5 clk = ~clk;

    softmax_max_sched #(.DW(DW), .LANES(LANES), .LAT(LAT), .NGRP(NGRP)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_flat(in_flat),
        .i_in_lane_valid(in_lv), .i_in_mode(in_mode), .i_in_last(in_last),
        .o_tree_en(tree_en), .o_tree_rst(tree_rst), .o_tree_length_mode(tree_lm),
        .o_tree_valid(tree_valid), .o_tree_flat(tree_flat),
        .i_tree_max64(max64), .i_tree_max32(max32), .i_tree_max16(max16),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_max(res_max), .o_res_cnt(res_cnt),
`ifdef MAX_SCHED_PERF_EN
        .o_perf_beats(perf_beats), .o_perf_stalls(perf_stalls), .o_perf_segs(perf_segs),
`endif
        .o_err(err)
    );

    // Behavioural max tree: LAT enabled stages, invalid lanes count as the most negative value.
    function automatic logic [DW-1:0] range_max(input logic [LANES*DW-1:0] f,
                                                input logic [LANES-1:0] v, input int lo, input int n);
        logic signed [DW-1:0] m;
        m = 16'sh8000;
        for (int k = lo; k < lo + n; k++)
            if (v[k] && $signed(f[k*DW +: DW]) > m) m = f[k*DW +: DW];
        return m;
    endfunction

    logic [DW-1:0]   t64 [LAT];
    logic [2*DW-1:0] t32 [LAT];
    logic [4*DW-1:0] t16 [LAT];

    always @(posedge clk) begin
        if (tree_rst) begin
            for (int i = 0; i < LAT; i++) begin
                t64[i] <= '0; t32[i] <= '0; t16[i] <= '0;
            end
        end else if (tree_en) begin
            t64[0] <= range_max(tree_flat, tree_valid, 0, 64);
            t32[0] <= {range_max(tree_flat, tree_valid, 32, 32), range_max(tree_flat, tree_valid, 0, 32)};
            t16[0] <= {range_max(tree_flat, tree_valid, 48, 16), range_max(tree_flat, tree_valid, 32, 16),
                       range_max(tree_flat, tree_valid, 16, 16), range_max(tree_flat, tree_valid, 0, 16)};
            for (int i = 1; i < LAT; i++) begin
                t64[i] <= t64[i-1]; t32[i] <= t32[i-1]; t16[i] <= t16[i-1];
            end
        end
    end

    assign max64 = t64[LAT-1];
    assign max32 = t32[LAT-1];
    assign max16 = t16[LAT-1];

    typedef struct {
        int mx [4];
        int cnt;
    } exp_t;

    exp_t q [$];
    int   errors = 0;
    int   checks = 0;
    int   results_seen = 0;
    bit   seg_open = 0;
    int   seg_mode = 0;
    int   acc [4];
    bit   err_exp = 0;
    bit   rr_rand = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: fold every segment's beats into group maxima using the first beat's mode.
    task automatic model_beat(input logic [LANES*DW-1:0] f, input logic [LANES-1:0] lv,
                              input logic [3:0] md, input logic last);
        int m, n, w, v;
        exp_t e;
        m = (md > 4'd2) ? 0 : int'(md);
        if (md > 4'd2) err_exp = 1;
        if (!seg_open) begin
            seg_open = 1;
            seg_mode = m;
            for (int g = 0; g < 4; g++) acc[g] = -32768;
        end else if (m != seg_mode) begin
            err_exp = 1;
        end
        n = 1 << seg_mode;
        w = LANES / n;
        for (int k = 0; k < LANES; k++) begin
            v = lv[k] ? int'($signed(f[k*DW +: DW])) : -32768;
            if (v > acc[k/w]) acc[k/w] = v;
        end
        if (last) begin
            e.cnt = n;
            for (int g = 0; g < 4; g++) e.mx[g] = (g < n) ? acc[g] : 0;
            q.push_back(e);
            seg_open = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                exp_t e;
                logic [63:0] ep;
                int t;
                results_seen++;
                if (q.size() == 0) begin
                    chk("res_unexpected", 64'(res_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    for (int g = 0; g < 4; g++) begin
                        t = e.mx[g];
                        ep[g*DW +: DW] = t[DW-1:0];
                    end
                    chk("res_max", res_max, ep);
                    chk("res_cnt", 64'(res_cnt), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [LANES*DW-1:0] f, input logic [LANES-1:0] lv,
                        input logic [3:0] md, input logic last);
        int n = 0;
        in_flat = f; in_lv = lv; in_mode = md; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        else model_beat(f, lv, md, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("res_wait", 64'(res_valid), 64'(1));
    endtask

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] f;
        for (int k = 0; k < LANES; k++) f[k*DW +: DW] = v;
        return f;
    endfunction

    function automatic logic [LANES*DW-1:0] rnd_flat();
        logic [LANES*DW-1:0] f;
        for (int k = 0; k < LANES; k++) f[k*DW +: DW] = 16'($urandom);
        return f;
    endfunction

    function automatic logic [LANES*DW-1:0] beat2(input int a, input int b);
        logic [LANES*DW-1:0] f;
        f = fill(16'hFF9C);
        f[3*DW +: DW]  = a[DW-1:0];
        f[40*DW +: DW] = b[DW-1:0];
        return f;
    endfunction

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*DW-1:0] f;
        logic [LANES-1:0]    lv;
        int s0, n, len, md;

        in_valid = 0; in_last = 0; in_mode = 0; in_lv = '0; in_flat = '0; res_ready = 0;
        rst = 0;
        #1 rst = 1;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_max", res_max, 64'(0));
        chk("rst_res_cnt", 64'(res_cnt), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_tree_rst", 64'(tree_rst), 64'(1));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rel_tree_rst", 64'(tree_rst), 64'(1));
        chk("rel_in_ready", 64'(in_ready), 64'(0));
        cycles(1);
        chk("run_tree_rst", 64'(tree_rst), 64'(0));
        chk("run_in_ready", 64'(in_ready), 64'(1));

        // 64-mode single beat, elements k-32
        for (int k = 0; k < LANES; k++) begin
            n = k - 32;
            f[k*DW +: DW] = n[DW-1:0];
        end
        send(f, '1, 4'd0, 1'b1);
        cycles(LAT - 1);
        chk("lat_early", 64'(res_valid), 64'(0));
        cycles(1);
        chk("lat_valid", 64'(res_valid), 64'(1));
        chk("t1_max", 64'(res_max[DW-1:0]), 64'(31));
        chk("t1_cnt", 64'(res_cnt), 64'(1));
        res_ready = 1;
        cycles(1);
        res_ready = 0;
        chk("t1_seen", 64'(results_seen), 64'(1));

        // 32-mode three-beat segment
        s0 = results_seen;
        send(beat2(5, -7), '1, 4'd1, 1'b0);
        send(beat2(9, -9), '1, 4'd1, 1'b0);
        send(beat2(2, -1), '1, 4'd1, 1'b1);
        wait_res();
        chk("t2_g0", 64'(res_max[DW-1:0]), 64'(16'd9));
        chk("t2_g1", 64'(res_max[2*DW-1:DW]), 64'(16'hFFFF));
        chk("t2_cnt", 64'(res_cnt), 64'(2));
        res_ready = 1;
        cycles(10);
        chk("t2_one_pulse", 64'(results_seen - s0), 64'(1));
        res_ready = 0;

        // 16-mode back-to-back single beats with the result undrained
        s0 = results_seen;
        send(rnd_flat(), '1, 4'd2, 1'b1);
        send(rnd_flat(), '1, 4'd2, 1'b1);
        cycles(10);
        chk("stall_res_valid", 64'(res_valid), 64'(1));
        chk("stall_tree_en", 64'(tree_en), 64'(0));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        res_ready = 1;
        cycles(1);
        res_ready = 0;
        chk("stall_first_drained", 64'(results_seen - s0), 64'(1));
        chk("stall_second_loaded", 64'(res_valid), 64'(1));
        res_ready = 1;
        cycles(3);
        chk("stall_second_drained", 64'(results_seen - s0), 64'(2));
        res_ready = 0;

        // negative values, signed compare
        f = fill(16'h8000);
        n = $urandom_range(0, LANES - 1);
        f[n*DW +: DW] = 16'hFFFE;
        send(f, '1, 4'd0, 1'b1);
        wait_res();
        chk("neg_max", 64'(res_max[DW-1:0]), 64'(16'hFFFE));
        res_ready = 1;
        cycles(2);
        res_ready = 0;

        // illegal mode and mid-segment mode change
        res_ready = 1;
        send(rnd_flat(), '1, 4'd5, 1'b1);
        cycles(2);
        chk("err_mode5", 64'(err), 64'(1));
        send(rnd_flat(), '1, 4'd0, 1'b0);
        send(rnd_flat(), '1, 4'd1, 1'b0);
        send(rnd_flat(), '1, 4'd0, 1'b1);
        cycles(10);
        chk("err_sticky", 64'(err), 64'(err_exp));
        res_ready = 0;

        // async reset mid-segment with a result pending
        send(rnd_flat(), '1, 4'd0, 1'b1);
        wait_res();
        f = fill(16'h7FFF);
        for (int b = 0; b < 4; b++) send(f, '1, 4'd1, 1'b0);
        #2 rst = 1;
        #1;
        chk("arst_res_valid", 64'(res_valid), 64'(0));
        chk("arst_err", 64'(err), 64'(0));
        q.delete();
        seg_open = 0;
        err_exp = 0;
        cycles(2);
        rst = 0;
        res_ready = 1;
        s0 = results_seen;
        cycles(12);
        chk("arst_no_result", 64'(results_seen - s0), 64'(0));
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < LANES; k++) begin
                n = $urandom_range(0, 2000) - 1000;
                f[k*DW +: DW] = n[DW-1:0];
            end
            send(f, '1, 4'd1, b == 1);
        end
        cycles(10);
        chk("arst_next_seg", 64'(results_seen - s0), 64'(1));

        // randomized segments with random back-pressure
        rr_rand = 1;
        for (int s = 0; s < 150; s++) begin
            md  = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                lv = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
                send(rnd_flat(), lv, 4'(md), b == len - 1);
                if ($urandom_range(0, 4) == 0) cycles(1);
            end
        end
        rr_rand = 0;
        res_ready = 1;
        n = 0;
        while ((q.size() != 0 || res_valid) && n < 300) begin
            cycles(1);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("final_err", 64'(err), 64'(err_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
